alu64bit_seq: RTL

- Sequential front-end for the combinational alu64bit: accepts operand words over a valid/ready handshake and drives the ALU inputs from registers.
- Captures s/cout into a result register and returns them over a second valid/ready handshake.
- Chains carry across consecutive words so software-visible multi-precision operations (128/192/256-bit) run as a stream of 64-bit beats.
- Sits between the operand source (register file or bench driver) and the alu64bit instance; the alu64bit itself is instantiated outside, beside this block.

---
 rtl/alu64bit_pkg.sv | 13 +
 rtl/alu64bit.sv | 31 +++
 rtl/alu64bit_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu64bit_pkg.sv
// Shared types and constants for the alu64bit datapath and its sequential front-end.
package alu64bit_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} seq_state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  localparam int ALU_WIDTH = 64;

endpackage

// File: rtl/alu64bit.sv
// Combinational 64-bit ALU: add/sub with carry, bitwise and/xor (cout=0 for logic ops).
module alu64bit
  import alu64bit_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = '0;
    case (op)
      OP_ADD:  sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      // cin=1 means "no borrow in"; cout=1 means "no borrow out"
      OP_SUB:  sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
      OP_AND:  sum = {1'b0, a & b};
      default: sum = {1'b0, a ^ b};
    endcase
  end

  assign s    = sum[WIDTH-1:0];
  assign cout = sum[WIDTH];

endmodule

// File: rtl/alu64bit_seq.sv
// Registered handshake front-end for alu64bit with carry chaining across beats
// and a forced chain break after MAX_WORDS beats.
module alu64bit_seq
  import alu64bit_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH,
  parameter int MAX_WORDS = 4,
  parameter int IDX_W     = $clog2(MAX_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  input  logic             in_last,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cout,
  output logic             out_last,
  output logic [IDX_W-1:0] out_idx,
  output logic             err
);

  seq_state_t       state_q;
  logic             in_ready_q, out_valid_q, out_cout_q, out_last_q, err_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q, out_s_q;
  logic [1:0]       alu_op_q;
  logic             alu_cin_q;
  logic [IDX_W-1:0] out_idx_q, idx_q;
  logic             carry_q, first_q, beat_last_q, force_q;
  logic             chain_end;

  assign chain_end = (idx_q == IDX_W'(MAX_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_cin_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
      out_cout_q  <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      err_q       <= 1'b0;
      carry_q     <= 1'b0;
      first_q     <= 1'b1;
      idx_q       <= '0;
      beat_last_q <= 1'b0;
      force_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            alu_a_q     <= in_a;
            alu_b_q     <= in_b;
            alu_op_q    <= in_op;
            alu_cin_q   <= first_q ? in_cin : carry_q;
            beat_last_q <= in_last | chain_end;
            force_q     <= chain_end & ~in_last;
            in_ready_q  <= 1'b0;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          // ALU output has settled from the registers loaded on entry
          out_s_q     <= alu_s;
          out_cout_q  <= alu_cout;
          out_last_q  <= beat_last_q;
          out_idx_q   <= idx_q;
          out_valid_q <= 1'b1;
          carry_q     <= alu_cout;
          if (beat_last_q) begin
            first_q <= 1'b1;
            idx_q   <= '0;
          end else begin
            first_q <= 1'b0;
            idx_q   <= idx_q + IDX_W'(1);
          end
          if (force_q) err_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_cin   = alu_cin_q;
  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_cout  = out_cout_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign err       = err_q;

endmodule
